run_ctrl: RTL and testbench



---
 rtl/run_ctrl_pkg.sv | 25 ++
 rtl/run_ctrl_perf_cnt.sv | 33 +++
 rtl/run_ctrl.sv | 121 ++++++++++++
 tb/tb_run_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run-control block: FSM states, debug commands and
// halt causes.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STEP   = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'd0,
    CMD_STEP = 2'd1,
    CMD_HALT = 2'd2,
    CMD_CLR  = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_INST = 2'd1,
    C_BP   = 2'd2,
    C_CMD  = 2'd3
  } cause_t;

endpackage

// File: rtl/run_ctrl_perf_cnt.sv
// Single performance counter with synchronous clear. Wraps to zero or
// sticks at all-ones depending on SAT. Clear beats increment.
module perf_cnt #(
  parameter int W   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;
  logic         at_max;

  assign at_max = &count_reg;
  assign q      = count_reg;

  // Counter register: reset, then clear, then (possibly saturating) increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !(SAT && at_max)) begin
      count_reg <= count_reg + ONE;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run-control and performance monitor: gates the core via core_run, accepts
// run/step/halt/clear commands, stops on halt instructions and a PC
// breakpoint, records why it stopped, and counts core cycles and events.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int N_EV      = 4,
  parameter int EV_W      = 16,
  parameter int ADR_W     = 16,
  parameter bit SAT       = 1'b0,
  parameter bit START_RUN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 is_halt,
  input  logic [ADR_W-1:0]     nextpc,
  input  logic [N_EV-1:0]      ev,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic                 bp_en,
  input  logic [ADR_W-1:0]     bp_adr,
  output logic                 core_run,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [N_EV*EV_W-1:0] ev_cnt
);

  localparam state_t RESET_STATE = START_RUN ? RUN : HALTED;

  state_t state_reg, state_next;
  cause_t cause_reg, cause_next;
  logic   skip_reg, skip_next;

  cmd_t op;
  logic bp_hit;
  logic stop_ev;
  logic clr_cmd;

  assign op       = cmd_t'(cmd_op);
  assign core_run = (state_reg == RUN) || (state_reg == STEP);
  assign halted   = (state_reg == HALTED);
  assign halt_cause = cause_reg;

  // skip_reg masks the breakpoint for the first cycle after resuming from it.
  assign bp_hit  = bp_en && (nextpc == bp_adr) && !skip_reg;
  assign stop_ev = core_run && (is_halt || bp_hit);
  assign clr_cmd = cmd_valid && (op == CMD_CLR);

  // State, cause and breakpoint-skip registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= RESET_STATE;
      cause_reg <= C_NONE;
      skip_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      skip_reg  <= skip_next;
    end
  end

  // Next-state logic: stop sources in priority order, resume on commands.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    skip_next  = skip_reg;
    case (state_reg)
      RUN, STEP: begin
        // Any core cycle consumes the one-shot breakpoint mask.
        skip_next = 1'b0;
        if (is_halt) begin
          state_next = HALTED;
          cause_next = C_INST;
        end else if (bp_hit) begin
          state_next = HALTED;
          cause_next = C_BP;
        end else if (state_reg == STEP) begin
          state_next = HALTED;
          cause_next = C_CMD;
        end else if (cmd_valid && (op == CMD_HALT)) begin
          state_next = HALTED;
          cause_next = C_CMD;
        end
      end
      HALTED: begin
        if (cmd_valid && (op == CMD_RUN || op == CMD_STEP)) begin
          state_next = (op == CMD_RUN) ? RUN : STEP;
          skip_next  = (cause_reg == C_BP);
        end
      end
      default: begin
        state_next = HALTED;
      end
    endcase
  end

  // Cycle counter: the cycle that stops the core is not counted.
  perf_cnt #(.W(CNT_W), .SAT(SAT)) u_cycle (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_cmd),
    .inc     (core_run && !stop_ev),
    .q       (cycle_cnt)
  );

  // Event counters: events in the stopping cycle still count.
  generate
    for (genvar gi = 0; gi < N_EV; gi++) begin : g_ev
      perf_cnt #(.W(EV_W), .SAT(SAT)) u_ev (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cmd),
        .inc     (core_run && ev[gi]),
        .q       (ev_cnt[gi*EV_W +: EV_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed reset/halt checks, a vector
// table, step pulses, randomized traffic against a reference model, and
// 8-bit wrap/saturate plus reset-during-step on two small instances.
module tb_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults: 32-bit cycle counter, wrap, start in RUN)
  logic        reset_n = 1'b0;
  logic        is_halt = 1'b0;
  logic [15:0] nextpc = 16'h0;
  logic [3:0]  ev = 4'h0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_adr = 16'h0020;
  logic        core_run, halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;
  logic [63:0] ev_cnt;

  run_ctrl #(.CNT_W(32), .N_EV(4), .EV_W(16), .ADR_W(16), .SAT(1'b0), .START_RUN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .is_halt(is_halt), .nextpc(nextpc), .ev(ev),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .bp_en(bp_en), .bp_adr(bp_adr),
    .core_run(core_run), .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .ev_cnt(ev_cnt)
  );

  // Small instances (8-bit cycle, 4-bit events, start HALTED), wrap and saturate
  logic        s_reset_n = 1'b0;
  logic        s_is_halt = 1'b0;
  logic [7:0]  s_nextpc = 8'h0;
  logic [1:0]  s_ev = 2'b00;
  logic        s_cmd_valid = 1'b0;
  logic [1:0]  s_cmd_op = 2'd0;
  logic        s_bp_en = 1'b0;
  logic [7:0]  s_bp_adr = 8'h0;
  logic        w_core_run, w_halted, t_core_run, t_halted;
  logic [1:0]  w_cause, t_cause;
  logic [7:0]  w_cyc, t_cyc, w_ev, t_ev;

  run_ctrl #(.CNT_W(8), .N_EV(2), .EV_W(4), .ADR_W(8), .SAT(1'b0), .START_RUN(1'b0)) dut_wrap (
    .clk(clk), .reset_n(s_reset_n), .is_halt(s_is_halt), .nextpc(s_nextpc), .ev(s_ev),
    .cmd_valid(s_cmd_valid), .cmd_op(s_cmd_op), .bp_en(s_bp_en), .bp_adr(s_bp_adr),
    .core_run(w_core_run), .halted(w_halted), .halt_cause(w_cause),
    .cycle_cnt(w_cyc), .ev_cnt(w_ev)
  );

  run_ctrl #(.CNT_W(8), .N_EV(2), .EV_W(4), .ADR_W(8), .SAT(1'b1), .START_RUN(1'b0)) dut_sat (
    .clk(clk), .reset_n(s_reset_n), .is_halt(s_is_halt), .nextpc(s_nextpc), .ev(s_ev),
    .cmd_valid(s_cmd_valid), .cmd_op(s_cmd_op), .bp_en(s_bp_en), .bp_adr(s_bp_adr),
    .core_run(t_core_run), .halted(t_halted), .halt_cause(t_cause),
    .cycle_cnt(t_cyc), .ev_cnt(t_ev)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the main instance. Modes: 0 running, 1 single step,
  // 2 stopped. Counters kept as plain integers reduced modulo 2^width.
  int          m_mode;
  int          m_cause;
  bit          m_skip;
  longint      m_cyc;
  int          m_ev [4];

  task automatic model_step();
    bit running, hit, clr;
    int nmode, ncause;
    bit nskip;
    if (!reset_n) begin
      m_mode = 0; m_cause = 0; m_skip = 0; m_cyc = 0;
      for (int i = 0; i < 4; i++) m_ev[i] = 0;
      return;
    end
    running = (m_mode != 2);
    hit     = bp_en && (nextpc == bp_adr) && !m_skip;
    clr     = cmd_valid && (cmd_op == 2'd3);
    if (clr) begin
      m_cyc = 0;
      for (int i = 0; i < 4; i++) m_ev[i] = 0;
    end else if (running) begin
      if (!(is_halt || hit)) m_cyc = (m_cyc + 1) % 64'h1_0000_0000;
      for (int i = 0; i < 4; i++) if (ev[i]) m_ev[i] = (m_ev[i] + 1) % 65536;
    end
    nmode = m_mode; ncause = m_cause; nskip = m_skip;
    if (running) begin
      nskip = 0;
      if (is_halt)                            begin nmode = 2; ncause = 1; end
      else if (hit)                           begin nmode = 2; ncause = 2; end
      else if (m_mode == 1)                   begin nmode = 2; ncause = 3; end
      else if (cmd_valid && cmd_op == 2'd2)   begin nmode = 2; ncause = 3; end
    end else if (cmd_valid && cmd_op <= 2'd1) begin
      nmode = (cmd_op == 2'd0) ? 0 : 1;
      nskip = (m_cause == 2);
    end
    m_mode = nmode; m_cause = ncause; m_skip = nskip;
  endtask

  task automatic model_check();
    chk("model_halted", {63'd0, halted}, {63'd0, m_mode == 2});
    chk("model_core_run", {63'd0, core_run}, {63'd0, m_mode != 2});
    chk("model_cause", {62'd0, halt_cause}, 64'(m_cause));
    chk("model_cycle_cnt", {32'd0, cycle_cnt}, 64'(m_cyc));
    for (int i = 0; i < 4; i++)
      chk($sformatf("model_ev_cnt%0d", i), {48'd0, ev_cnt[i*16 +: 16]}, 64'(m_ev[i]));
  endtask

  // One clock: advance model with current inputs, clock, compare 1ns later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle_main();
    is_halt = 0; cmd_valid = 0; cmd_op = 0; ev = 0; bp_en = 0; nextpc = 16'h0010;
  endtask

  typedef struct {
    logic        cv;
    logic [1:0]  op;
    logic        ih;
    logic        be;
    logic [15:0] pc;
    logic [3:0]  evi;
    logic        e_halted;
    logic [1:0]  e_cause;
    logic [31:0] e_cnt;
    logic [15:0] e_ev0;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int     run_hi;
    logic [31:0] cnt0;

    tbl[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 16'h0010, 4'h1, 1'b1, 2'd1, 32'd0, 16'd0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0010, 4'h0, 1'b0, 2'd1, 32'd0, 16'd0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 16'h0010, 4'h0, 1'b0, 2'd1, 32'd1, 16'd0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b1, 16'h0020, 4'h0, 1'b1, 2'd2, 32'd1, 16'd0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b1, 16'h0020, 4'h0, 1'b0, 2'd2, 32'd1, 16'd0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 16'h0020, 4'h0, 1'b0, 2'd2, 32'd2, 16'd0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 16'h0022, 4'h0, 1'b0, 2'd2, 32'd3, 16'd0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 16'h0020, 4'h0, 1'b1, 2'd1, 32'd3, 16'd0};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 1'b0, 16'h0030, 4'h0, 1'b0, 2'd1, 32'd3, 16'd0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 16'h0030, 4'h0, 1'b1, 2'd3, 32'd4, 16'd0};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 1'b0, 16'h0030, 4'h0, 1'b1, 2'd3, 32'd4, 16'd0};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0030, 4'h0, 1'b0, 2'd3, 32'd4, 16'd0};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 1'b0, 16'h0030, 4'h0, 1'b1, 2'd3, 32'd5, 16'd0};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0030, 4'h0, 1'b0, 2'd3, 32'd5, 16'd0};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 1'b0, 16'h0030, 4'h1, 1'b0, 2'd3, 32'd0, 16'd0};
    tbl[15] = '{1'b1, 2'd1, 1'b0, 1'b0, 16'h0030, 4'h1, 1'b0, 2'd3, 32'd1, 16'd1};
    tbl[16] = '{1'b1, 2'd2, 1'b0, 1'b0, 16'h0030, 4'h0, 1'b1, 2'd3, 32'd2, 16'd1};

    // Reset with START_RUN = 1
    idle_main();
    reset_n = 0;
    cycle(); cycle();
    chk("reset_halted", {63'd0, halted}, 64'd0);
    chk("reset_core_run", {63'd0, core_run}, 64'd1);
    chk("reset_cause", {62'd0, halt_cause}, 64'd0);
    chk("reset_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
    $display("reset: halted=%0b core_run=%0b cnt=%0d", halted, core_run, cycle_cnt);

    // Ten running cycles, then a halt instruction
    reset_n = 1;
    for (int i = 0; i < 10; i++) cycle();
    is_halt = 1;
    cycle();
    is_halt = 0;
    chk("halt_inst_halted", {63'd0, halted}, 64'd1);
    chk("halt_inst_cause", {62'd0, halt_cause}, 64'd1);
    chk("halt_inst_cnt", {32'd0, cycle_cnt}, 64'd10);
    for (int i = 0; i < 3; i++) cycle();
    chk("halt_frozen_cnt", {32'd0, cycle_cnt}, 64'd10);
    $display("halt inst: halted=%0b cause=%0d cnt=%0d", halted, halt_cause, cycle_cnt);

    // Vector table
    for (int v = 0; v < 17; v++) begin
      cmd_valid = tbl[v].cv; cmd_op = tbl[v].op; is_halt = tbl[v].ih;
      bp_en = tbl[v].be; nextpc = tbl[v].pc; ev = tbl[v].evi;
      cycle();
      chk($sformatf("vec%0d_halted", v), {63'd0, halted}, {63'd0, tbl[v].e_halted});
      chk($sformatf("vec%0d_cause", v), {62'd0, halt_cause}, {62'd0, tbl[v].e_cause});
      chk($sformatf("vec%0d_cnt", v), {32'd0, cycle_cnt}, {32'd0, tbl[v].e_cnt});
      chk($sformatf("vec%0d_ev0", v), {48'd0, ev_cnt[15:0]}, {48'd0, tbl[v].e_ev0});
      $display("vec %0d: halted=%0b cause=%0d cnt=%0d ev0=%0d", v, halted, halt_cause, cycle_cnt, ev_cnt[15:0]);
    end
    idle_main();

    // Three STEP pulses spaced four cycles apart
    cnt0 = cycle_cnt;
    run_hi = 0;
    for (int p = 0; p < 3; p++) begin
      cmd_valid = 1; cmd_op = 2'd1;
      cycle();
      if (core_run) run_hi++;
      cmd_valid = 0;
      for (int k = 0; k < 3; k++) begin
        cycle();
        if (core_run) run_hi++;
      end
      $display("step %0d: cnt=%0d cause=%0d", p, cycle_cnt, halt_cause);
    end
    chk("step_run_cycles", 64'(run_hi), 64'd3);
    chk("step_cnt_delta", {32'd0, cycle_cnt - cnt0}, 64'd3);
    chk("step_cause", {62'd0, halt_cause}, 64'd3);

    // Randomized traffic against the model
    for (int r = 0; r < 400; r++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      is_halt   = ($urandom_range(0, 15) == 0);
      bp_en     = 1'($urandom_range(0, 1));
      nextpc    = ($urandom_range(0, 3) == 0) ? 16'h0020 : 16'($urandom_range(0, 63));
      ev        = 4'($urandom_range(0, 15));
      cycle();
    end
    reset_n = 1;
    idle_main();
    $display("random: %0d checks so far, errors=%0d", checks, errors);

    // 8-bit wrap / saturate: 257 counted cycles
    s_reset_n = 0;
    cycle();
    s_reset_n = 1;
    chk("small_reset_halted_wrap", {63'd0, w_halted}, 64'd1);
    chk("small_reset_halted_sat", {63'd0, t_halted}, 64'd1);
    s_cmd_valid = 1; s_cmd_op = 2'd0;
    cycle();
    s_cmd_valid = 0; s_ev = 2'b01;
    for (int i = 0; i < 256; i++) cycle();
    s_cmd_valid = 1; s_cmd_op = 2'd2;
    cycle();
    s_cmd_valid = 0; s_ev = 2'b00;
    chk("wrap_cycle_cnt", {56'd0, w_cyc}, 64'd1);
    chk("sat_cycle_cnt", {56'd0, t_cyc}, 64'd255);
    chk("wrap_ev0", {60'd0, w_ev[3:0]}, 64'd1);
    chk("sat_ev0", {60'd0, t_ev[3:0]}, 64'd15);
    chk("wrap_halted", {63'd0, w_halted}, 64'd1);
    chk("sat_cause", {62'd0, t_cause}, 64'd3);
    $display("wrap/sat: wrap_cnt=%0d sat_cnt=%0d wrap_ev0=%0d sat_ev0=%0d", w_cyc, t_cyc, w_ev[3:0], t_ev[3:0]);

    // Reset while in STEP
    s_cmd_valid = 1; s_cmd_op = 2'd1;
    cycle();
    s_cmd_valid = 0;
    chk("step_entered", {63'd0, w_core_run}, 64'd1);
    s_reset_n = 0;
    cycle();
    chk("rst_step_halted", {63'd0, w_halted}, 64'd1);
    chk("rst_step_cnt", {56'd0, w_cyc}, 64'd0);
    chk("rst_step_ev", {56'd0, w_ev}, 64'd0);
    chk("rst_step_cause", {62'd0, w_cause}, 64'd0);
    chk("rst_step_sat_cnt", {56'd0, t_cyc}, 64'd0);
    s_reset_n = 1;
    $display("reset in step: halted=%0b cnt=%0d cause=%0d", w_halted, w_cyc, w_cause);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
